// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: drains a registered-output FIFO one byte at a time into
// asynchronous serial frames (start, 8 data LSB first, stop) and counts frames.
module fifo_tx_serializer #(
  parameter int DIV   = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_n,
  input  logic             enable,
  input  logic             f_empty_n,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             read,
  output logic             tx,
  output logic             busy,
  output logic [7:0]       sent_cnt
);
  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;
  state_t state, state_nxt;
  logic [7:0] div_cnt;
  logic [2:0] bit_idx;
  logic [WIDTH-1:0] shreg;
  logic last, go;
  assign last = div_cnt == 8'(DIV - 1);
  assign go   = enable && f_empty_n;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = go ? REQ : IDLE;
      REQ:     state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   state_nxt = last ? DATA : START;
      DATA:    state_nxt = (last && bit_idx == 3'(WIDTH - 1)) ? STOP : DATA;
      STOP:    state_nxt = last ? (go ? REQ : IDLE) : STOP;
      default: state_nxt = IDLE;
    endcase
    if (!clear_n) state_nxt = IDLE;
  end
  // Read is gated by clear so a clear landing on REQ never pops the FIFO.
  assign read = state == REQ && clear_n;
  assign busy = state != IDLE;
  assign tx   = state == START ? 1'b0 : state == DATA ? shreg[bit_idx] : 1'b1;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      sent_cnt <= '0;
    end else if (!clear_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      sent_cnt <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= (state_nxt != state || last) ? '0 : div_cnt + 8'd1;
      bit_idx <= state_nxt != state ? '0 : (state == DATA && last) ? bit_idx + 3'd1 : bit_idx;
      if (state == LOAD) shreg <= fifo_data;
      if (state == STOP && last) sent_cnt <= sent_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_fifo_tx_serializer.sv
// tb_fifo_tx_serializer: directed scenarios against a behavioural registered-output FIFO;
// a second DIV=2 instance exercises the frame counter wrap.
module tb_fifo_tx_serializer;
  localparam int DIV = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, clear_n, enable, enable2;
  logic read, tx, busy, read2, tx2, busy2;
  logic [7:0] sent_cnt, sent2;
  logic [7:0] fdata = 8'h00, fdata2 = 8'h00;
  logic f_empty_n, f_empty_n2;
  logic [7:0] mem [32];
  int wp = 0, rp = 0, wr2 = 0, rd2 = 0, cyc = 0, nreads = 0;
  int read_log [64];
  int total = 0, bad = 0;
  assign f_empty_n  = wp != rp;
  assign f_empty_n2 = wr2 != rd2;

  fifo_tx_serializer #(.DIV(DIV), .WIDTH(8)) dut (
    .clock(clk), .reset_n(reset_n), .clear_n(clear_n), .enable(enable),
    .f_empty_n(f_empty_n), .fifo_data(fdata), .read(read), .tx(tx),
    .busy(busy), .sent_cnt(sent_cnt));
  fifo_tx_serializer #(.DIV(2), .WIDTH(8)) dut2 (
    .clock(clk), .reset_n(reset_n), .clear_n(clear_n), .enable(enable2),
    .f_empty_n(f_empty_n2), .fifo_data(fdata2), .read(read2), .tx(tx2),
    .busy(busy2), .sent_cnt(sent2));

  // FIFO models: data appears the cycle after read, clear empties them
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (read) begin
      if (nreads < 64) read_log[nreads] <= cyc;
      nreads <= nreads + 1;
    end
    if (!clear_n) rp <= wp;
    else if (read) begin
      total++;
      if (wp == rp) begin bad++; $display("FAIL over_read got=read_on_empty want=no_read"); end
      else begin fdata <= mem[rp % 32]; rp <= rp + 1; end
    end
    if (!clear_n) rd2 <= wr2;
    else if (read2) begin
      total++;
      if (wr2 == rd2) begin bad++; $display("FAIL over_read2 got=read_on_empty want=no_read"); end
      else begin fdata2 <= 8'(rd2); rd2 <= rd2 + 1; end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b);
    mem[wp % 32] = b;
    wp++;
  endtask

  task automatic wait_start(output bit ok, output int t);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  task automatic capture(input int drop_at, output logic [9:0] f);
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < DIV; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (k * DIV + c == drop_at) enable = 1'b0;
        if (c == 0) f[k] = tx;
        else if (tx !== f[k]) f[k] = 1'bx;
      end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; clear_n = 1'b1; enable = 1'b0; enable2 = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
    total++; if (read !== 1'b0) begin bad++; $display("FAIL reset_read got=%b want=0", read); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (sent_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", sent_cnt); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0 || nreads != 0) begin bad++; $display("FAIL reset_idle got=busy%b/reads%0d want=0/0", busy, nreads); end
  endtask

  task automatic test_single;
    bit ok; int t, r0; logic [9:0] f;
    r0 = nreads;
    push(8'hA5);
    enable = 1'b1;
    wait_start(ok, t);
    total++; if (!ok) begin bad++; $display("FAIL single_start got=timeout want=start_bit"); end
    capture(-1, f);
    total++; if (f !== 10'b1_1010_0101_0) begin bad++; $display("FAIL single_frame got=%b want=%b", f, 10'b1_1010_0101_0); end
    total++; if (nreads - r0 != 1) begin bad++; $display("FAIL single_reads got=%0d want=1", nreads - r0); end
    total++; if (t - read_log[r0] != 2) begin bad++; $display("FAIL single_latency got=%0d want=2", t - read_log[r0]); end
    @(negedge clk);
    total++; if (sent_cnt !== 8'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", sent_cnt); end
    total++; if (busy !== 1'b0 || f_empty_n !== 1'b0) begin bad++; $display("FAIL single_idle got=busy%b/ne%b want=0/0", busy, f_empty_n); end
  endtask

  task automatic test_burst;
    bit ok; int r0; int t [3]; logic [9:0] f;
    logic [7:0] bs [3] = '{8'h00, 8'hFF, 8'h3C};
    r0 = nreads;
    for (int i = 0; i < 3; i++) push(bs[i]);
    for (int i = 0; i < 3; i++) begin
      wait_start(ok, t[i]);
      total++; if (!ok) begin bad++; $display("FAIL burst_start%0d got=timeout want=start_bit", i); end
      capture(-1, f);
      total++; if (f !== {1'b1, bs[i], 1'b0}) begin bad++; $display("FAIL burst_frame%0d got=%b want=%b", i, f, {1'b1, bs[i], 1'b0}); end
    end
    total++; if (t[1] - t[0] != 42 || t[2] - t[1] != 42) begin bad++; $display("FAIL burst_period got=%0d,%0d want=42,42", t[1] - t[0], t[2] - t[1]); end
    total++; if (read_log[r0 + 1] - read_log[r0] != 42 || read_log[r0 + 2] - read_log[r0 + 1] != 42) begin
      bad++; $display("FAIL burst_read_spacing got=%0d,%0d want=42,42", read_log[r0 + 1] - read_log[r0], read_log[r0 + 2] - read_log[r0 + 1]); end
    @(negedge clk);
    total++; if (sent_cnt !== 8'd4) begin bad++; $display("FAIL burst_cnt got=%0d want=4", sent_cnt); end
  endtask

  task automatic test_enable_drop;
    bit ok; int t, r0; logic [9:0] f;
    enable = 1'b0;
    r0 = nreads;
    push(8'h5A);
    push(8'hC3);
    repeat (3) @(negedge clk);
    total++; if (nreads != r0) begin bad++; $display("FAIL drop_hold got=%0d want=%0d", nreads, r0); end
    enable = 1'b1;
    wait_start(ok, t);
    capture(DIV * 4 + 1, f);
    total++; if (f !== {1'b1, 8'h5A, 1'b0}) begin bad++; $display("FAIL drop_frame1 got=%b want=%b", f, {1'b1, 8'h5A, 1'b0}); end
    repeat (20) @(negedge clk);
    total++; if (nreads - r0 != 1) begin bad++; $display("FAIL drop_reads got=%0d want=1", nreads - r0); end
    total++; if (wp - rp != 1) begin bad++; $display("FAIL drop_used got=%0d want=1", wp - rp); end
    total++; if (busy !== 1'b0 || sent_cnt !== 8'd5) begin bad++; $display("FAIL drop_idle got=busy%b/cnt%0d want=0/5", busy, sent_cnt); end
    enable = 1'b1;
    wait_start(ok, t);
    total++; if (!ok) begin bad++; $display("FAIL drop_resume got=timeout want=start_bit"); end
    capture(-1, f);
    total++; if (f !== {1'b1, 8'hC3, 1'b0}) begin bad++; $display("FAIL drop_frame2 got=%b want=%b", f, {1'b1, 8'hC3, 1'b0}); end
    @(negedge clk);
    total++; if (sent_cnt !== 8'd6) begin bad++; $display("FAIL drop_cnt got=%0d want=6", sent_cnt); end
  endtask

  task automatic test_async_reset;
    bit ok; int t, r0;
    push(8'h96);
    wait_start(ok, t);
    repeat (DIV + 1) @(negedge clk);
    total++; if (tx !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL areset_pre got=tx%b/busy%b want=0/1", tx, busy); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL areset_tx got=%b want=1", tx); end
    total++; if (read !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL areset_ctl got=read%b/busy%b want=0/0", read, busy); end
    total++; if (sent_cnt !== 8'd0) begin bad++; $display("FAIL areset_cnt got=%0d want=0", sent_cnt); end
    @(negedge clk);
    reset_n = 1'b1;
    r0 = nreads;
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b0 || nreads != r0) begin bad++; $display("FAIL areset_idle got=busy%b/reads%0d want=0/%0d", busy, nreads, r0); end
  endtask

  task automatic test_clear;
    bit ok, found; int t, lows; logic [9:0] f;
    push(8'h77);
    push(8'h11);
    wait_start(ok, t);
    capture(-1, f);
    total++; if (f !== {1'b1, 8'h77, 1'b0}) begin bad++; $display("FAIL clear_frame got=%b want=%b", f, {1'b1, 8'h77, 1'b0}); end
    wait_start(ok, t);
    total++; if (!ok || sent_cnt !== 8'd1) begin bad++; $display("FAIL clear_pre got=ok%b/cnt%0d want=1/1", ok, sent_cnt); end
    clear_n = 1'b0;
    #1;
    total++; if (read !== 1'b0) begin bad++; $display("FAIL clear_start_read got=%b want=0", read); end
    @(negedge clk);
    clear_n = 1'b1;
    total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL clear_start_state got=tx%b/busy%b want=1/0", tx, busy); end
    total++; if (sent_cnt !== 8'd0 || wp != rp) begin bad++; $display("FAIL clear_start_cnt got=cnt%0d/used%0d want=0/0", sent_cnt, wp - rp); end
    push(8'h22);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (read === 1'b1) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL clear_req_seen got=timeout want=read"); end
    clear_n = 1'b0;
    #1;
    total++; if (read !== 1'b0) begin bad++; $display("FAIL clear_req_read got=%b want=0", read); end
    @(negedge clk);
    clear_n = 1'b1;
    total++; if (busy !== 1'b0 || wp != rp) begin bad++; $display("FAIL clear_req_state got=busy%b/used%0d want=0/0", busy, wp - rp); end
    lows = 0;
    repeat (30) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    total++; if (lows != 0 || sent_cnt !== 8'd0) begin bad++; $display("FAIL clear_quiet got=lows%0d/cnt%0d want=0/0", lows, sent_cnt); end
  endtask

  task automatic test_wrap;
    bit done;
    enable2 = 1'b1;
    wr2 = 255;
    done = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (rd2 == wr2 && !busy2) begin done = 1'b1; break; end
    end
    total++; if (!done) begin bad++; $display("FAIL wrap_255_done got=timeout want=idle"); end
    total++; if (sent2 !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d want=255", sent2); end
    wr2 = 256;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rd2 == wr2 && !busy2) begin done = 1'b1; break; end
    end
    total++; if (!done) begin bad++; $display("FAIL wrap_256_done got=timeout want=idle"); end
    total++; if (sent2 !== 8'd0 || tx2 !== 1'b1) begin bad++; $display("FAIL wrap_256 got=cnt%0d/tx%b want=0/1", sent2, tx2); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_enable_drop;
    test_async_reset;
    test_clear;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
